// File: rtl/bomberman_pkg.sv
// Shared constants for the bomberman play-field: wall origin, tile size, blast
// reach, the bomb FSM state encoding and the tile-snap helper.
package bomberman_pkg;

  localparam logic [9:0] MIN_X   = 10'd143;
  localparam logic [9:0] MIN_Y   = 10'd34;
  localparam int         TILE    = 16;
  localparam logic [10:0] E_WN    = 11'd48;
  localparam logic [10:0] E_WP    = 11'd63;
  localparam logic [10:0] E_WIDTH = 11'd16;

  localparam logic [9:0]  TILE_MASK = ~10'(TILE - 1);
  localparam logic [10:0] TILE_SPAN = 11'(TILE - 1);
  localparam logic [10:0] E_SPAN    = E_WN + E_WP;
  localparam logic [10:0] E_TAIL    = E_WIDTH - 11'd1;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_ARMED   = 4'b0010,
    ST_EXPLODE = 4'b0100,
    ST_BLAST   = 4'b1000
  } bomb_state_t;

  // Round a sprite coordinate to the nearest tile origin relative to the wall.
  function automatic logic [9:0] snap_tile(input logic [9:0] pos, input logic [9:0] base);
    logic [9:0] off;
    off = (pos - base) + 10'd8;
    return base + (off & TILE_MASK);
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Two-flop synchroniser for an asynchronous button followed by a registered
// one-cycle rising-edge pulse.
module btn_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync1_q, sync2_q, prev_q, pulse_q;
  logic pulse_d;

  always_comb begin
    pulse_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/bomb_controller.sv
// Single-bomb lifecycle: place on C, fuse, one-cycle detonation pulse, blast window.
// Optional BOMB_REMOTE_DETONATE_EN: a C press while armed detonates on the next cycle.
module bomb_controller
  import bomberman_pkg::*;
#(
  parameter int FUSE_TICKS  = 150_000_000,
  parameter int BLAST_TICKS = 50_000_000,
  parameter int CNT_W       = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       C,
  input  logic       game_over,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [9:0] v_x,
  input  logic [9:0] v_y,
  output logic       bomb_active,
  output logic [9:0] bomb_x,
  output logic [9:0] bomb_y,
  output logic       explosion_SCEN,
  output logic [9:0] e_x,
  output logic [9:0] e_y,
  output logic       bomb_on,
  output logic       exp_on
);

  localparam logic [CNT_W-1:0] FUSE_LAST  = CNT_W'(FUSE_TICKS - 1);
  localparam logic [CNT_W-1:0] BLAST_LAST = CNT_W'(BLAST_TICKS - 1);

  logic c_edge;

  btn_edge_detect u_c_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (C),
    .pulse (c_edge)
  );

  bomb_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bomb_active_q, bomb_active_d;
  logic [9:0]       bomb_x_q, bomb_x_d, bomb_y_q, bomb_y_d;
  logic             explosion_q, explosion_d;
  logic [9:0]       e_x_q, e_x_d, e_y_q, e_y_d;
  logic             fire;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bomb_active_d = bomb_active_q;
    bomb_x_d      = bomb_x_q;
    bomb_y_d      = bomb_y_q;
    explosion_d   = 1'b0;
    e_x_d         = e_x_q;
    e_y_d         = e_y_q;
`ifdef BOMB_REMOTE_DETONATE_EN
    fire = (cnt_q == FUSE_LAST) || c_edge;
`else
    fire = (cnt_q == FUSE_LAST);
`endif
    case (state_q)
      ST_IDLE: begin
        if (c_edge && !game_over) begin
          state_d       = ST_ARMED;
          cnt_d         = '0;
          bomb_active_d = 1'b1;
          bomb_x_d      = snap_tile(b_x, MIN_X);
          bomb_y_d      = snap_tile(b_y, MIN_Y);
        end
      end
      ST_ARMED: begin
        // Outputs are registered, so the detonation values load on entry to EXPLODE.
        if (fire) begin
          state_d       = ST_EXPLODE;
          cnt_d         = '0;
          bomb_active_d = 1'b0;
          explosion_d   = 1'b1;
          e_x_d         = bomb_x_q;
          e_y_d         = bomb_y_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_EXPLODE: begin
        state_d = ST_BLAST;
        cnt_d   = '0;
      end
      ST_BLAST: begin
        if (cnt_q == BLAST_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        cnt_d         = '0;
        bomb_active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bomb_active_q <= 1'b0;
      bomb_x_q      <= '0;
      bomb_y_q      <= '0;
      explosion_q   <= 1'b0;
      e_x_q         <= '0;
      e_y_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bomb_active_q <= bomb_active_d;
      bomb_x_q      <= bomb_x_d;
      bomb_y_q      <= bomb_y_d;
      explosion_q   <= explosion_d;
      e_x_q         <= e_x_d;
      e_y_q         <= e_y_d;
    end
  end

  // Pixel hit tests run in 11 bits with the pixel shifted by E_WN so the
  // left/up blast arms never need a subtraction that could wrap.
  logic [10:0] vx_w, vy_w, vx_off, vy_off, ex_w, ey_w, bx_w, by_w;
  logic        h_beam, v_beam;

  always_comb begin
    vx_w   = {1'b0, v_x};
    vy_w   = {1'b0, v_y};
    vx_off = vx_w + E_WN;
    vy_off = vy_w + E_WN;
    ex_w   = {1'b0, e_x_q};
    ey_w   = {1'b0, e_y_q};
    bx_w   = {1'b0, bomb_x_q};
    by_w   = {1'b0, bomb_y_q};
    h_beam = (vx_off >= ex_w) && (vx_off <= ex_w + E_SPAN) &&
             (vy_off >= ey_w + E_WN) && (vy_off <= ey_w + E_WN + E_TAIL);
    v_beam = (vx_off >= ex_w + E_WN) && (vx_off <= ex_w + E_WN + E_TAIL) &&
             (vy_off >= ey_w) && (vy_off <= ey_w + E_SPAN);
    exp_on  = (state_q == ST_BLAST) && (h_beam || v_beam);
    bomb_on = bomb_active_q &&
              (vx_w >= bx_w) && (vx_w <= bx_w + TILE_SPAN) &&
              (vy_w >= by_w) && (vy_w <= by_w + TILE_SPAN);
  end

  assign bomb_active    = bomb_active_q;
  assign bomb_x         = bomb_x_q;
  assign bomb_y         = bomb_y_q;
  assign explosion_SCEN = explosion_q;
  assign e_x            = e_x_q;
  assign e_y            = e_y_q;

endmodule

// File: tb/tb_bomb_controller.sv
// Self-checking bench for bomb_controller with a short fuse (10) and blast (5).
// Table vectors for snapping and blast geometry, hand sequences for timing corners,
// and a randomized pass against arithmetic reference functions.
module tb_bomb_controller;

  localparam int FUSE  = 10;
  localparam int BLAST = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       c_btn = 1'b0;
  logic       game_over = 1'b0;
  logic [9:0] b_x = '0, b_y = '0, v_x = '0, v_y = '0;
  logic       bomb_active, explosion_SCEN, bomb_on, exp_on;
  logic [9:0] bomb_x, bomb_y, e_x, e_y;

  int n_checks = 0;
  int n_fail   = 0;
  int txn      = 0;

  always #5 clk = ~clk;

  bomb_controller #(
    .FUSE_TICKS  (FUSE),
    .BLAST_TICKS (BLAST),
    .CNT_W       (28)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .C              (c_btn),
    .game_over      (game_over),
    .b_x            (b_x),
    .b_y            (b_y),
    .v_x            (v_x),
    .v_y            (v_y),
    .bomb_active    (bomb_active),
    .bomb_x         (bomb_x),
    .bomb_y         (bomb_y),
    .explosion_SCEN (explosion_SCEN),
    .e_x            (e_x),
    .e_y            (e_y),
    .bomb_on        (bomb_on),
    .exp_on         (exp_on)
  );

  // Reference model: nearest tile origin by integer division, hit tests by offset.
  function automatic int snap_ref(input int p, input int base);
    return base + ((p - base + 8) / 16) * 16;
  endfunction

  function automatic bit bomb_ref(input int vx, input int vy, input int bx, input int by);
    return (vx >= bx) && (vx < bx + 16) && (vy >= by) && (vy < by + 16);
  endfunction

  function automatic bit exp_ref(input int vx, input int vy, input int ex, input int ey);
    int dx, dy;
    dx = vx - ex;
    dy = vy - ey;
    return (dx >= -48 && dx <= 63 && dy >= 0 && dy <= 15) ||
           (dx >= 0 && dx <= 15 && dy >= -48 && dy <= 63);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Press C for one cycle; rise_k is the negedge count at which bomb_active is seen.
  task automatic place(input int bx, input int by, output int rise_k);
    int k;
    k      = 0;
    rise_k = -1;
    b_x    = 10'(bx);
    b_y    = 10'(by);
    c_btn  = 1'b1;
    while (rise_k < 0 && k < 12) begin
      @(negedge clk);
      k++;
      c_btn = 1'b0;
      if (bomb_active) rise_k = k;
    end
  endtask

  // Count cycles from the bomb_active rise to explosion_SCEN; optionally press C at cycle c_at.
  task automatic run_fuse(input int c_at, output int dt);
    dt = -1;
    for (int k = 1; k <= 40 && dt < 0; k++) begin
      @(negedge clk);
      if (explosion_SCEN) dt = k;
      c_btn = (k == c_at);
    end
    c_btn = 1'b0;
  endtask

  // Place, check arming, fuse and detonation; returns one cycle into BLAST.
  task automatic bomb_cycle(input int bx, input int by, input int ebx, input int eby,
                            input int c_at, input int exp_dt);
    int rise_k, dt;
    txn++;
    place(bx, by, rise_k);
    check("rise latency", rise_k, 4);
    check("bomb_x", bomb_x, ebx);
    check("bomb_y", bomb_y, eby);
    v_x = 10'(ebx + 15); v_y = 10'(eby + 15); #1;
    check("bomb_on corner", bomb_on, bomb_ref(ebx + 15, eby + 15, ebx, eby));
    v_x = 10'(ebx + 16); v_y = 10'(eby); #1;
    check("bomb_on outside", bomb_on, bomb_ref(ebx + 16, eby, ebx, eby));
    run_fuse(c_at, dt);
    check("fuse cycles", dt, exp_dt);
    check("e_x", e_x, ebx);
    check("e_y", e_y, eby);
    check("active cleared", bomb_active, 0);
    @(negedge clk);
    check("pulse width", explosion_SCEN, 0);
    $display("txn %0d b=(%0d,%0d) bomb=(%0d,%0d) e=(%0d,%0d) fuse=%0d",
             txn, bx, by, bomb_x, bomb_y, e_x, e_y, dt);
  endtask

  task automatic finish_blast(input int ex, input int ey);
    repeat (BLAST) @(negedge clk);
    v_x = 10'(ex); v_y = 10'(ey); #1;
    check("exp_on idle", exp_on, 0);
  endtask

  typedef struct {
    int bx, by, ebx, eby;
  } snap_vec_t;

  typedef struct {
    int vx, vy;
    bit hit;
  } geo_vec_t;

  snap_vec_t snaps[6];
  geo_vec_t  geos[10];

  initial begin
    int cnt, rise_k, dt, bx, by, ebx, eby, vx, vy;
    int remote_dt;

    snaps[0] = '{152, 50, 159, 50};
    snaps[1] = '{143, 34, 143, 34};
    snaps[2] = '{150, 41, 143, 34};
    snaps[3] = '{151, 42, 159, 50};
    snaps[4] = '{774, 434, 767, 434};
    snaps[5] = '{166, 57, 159, 50};

    geos[0] = '{111, 50, 1'b1};
    geos[1] = '{110, 50, 1'b0};
    geos[2] = '{159, 113, 1'b1};
    geos[3] = '{159, 114, 1'b0};
    geos[4] = '{175, 66, 1'b0};
    geos[5] = '{222, 65, 1'b1};
    geos[6] = '{223, 50, 1'b0};
    geos[7] = '{174, 2, 1'b1};
    geos[8] = '{175, 2, 1'b0};
    geos[9] = '{158, 1, 1'b0};

    // Reset held: stimulus wiggles, every output stays zero.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      c_btn = 1'(i % 2);
      b_x   = 10'(150 + i * 7);
      v_x   = 10'(140 + i * 5);
      #1;
      check("reset outputs", {bomb_active, bomb_x, bomb_y, explosion_SCEN, e_x, e_y, bomb_on, exp_on}, 0);
    end
    c_btn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cnt += int'(explosion_SCEN) + int'(bomb_active);
    end
    check("post-reset idle", cnt, 0);

    // Snap table plus full fuse timing; blast geometry on the first entry.
    for (int i = 0; i < 6; i++) begin
      bomb_cycle(snaps[i].bx, snaps[i].by, snaps[i].ebx, snaps[i].eby, 0, FUSE);
      if (i == 0) begin
        for (int g = 0; g < 10; g++) begin
          v_x = 10'(geos[g].vx); v_y = 10'(geos[g].vy); #0.5;
          check("exp_on geometry", exp_on, geos[g].hit);
        end
      end
      finish_blast(snaps[i].ebx, snaps[i].eby);
    end

    // Holding C gives exactly one bomb.
    b_x = 10'd200; b_y = 10'd100;
    c_btn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt += int'(explosion_SCEN);
    end
    c_btn = 1'b0;
    check("held C pulses", cnt, 1);
    repeat (3) @(negedge clk);

    // game_over blocks placement.
    game_over = 1'b1;
    place(200, 100, rise_k);
    check("game_over blocks", rise_k, -1);
    game_over = 1'b0;
    repeat (3) @(negedge clk);

    // game_over raised while armed does not stop the detonation.
    place(200, 100, rise_k);
    check("rise latency go", rise_k, 4);
    game_over = 1'b1;
    run_fuse(0, dt);
    check("armed survives game_over", dt, FUSE);
    game_over = 1'b0;
    repeat (BLAST + 3) @(negedge clk);

    // C press three cycles into the fuse.
`ifdef BOMB_REMOTE_DETONATE_EN
    remote_dt = 7;
`else
    remote_dt = FUSE;
`endif
    bomb_cycle(152, 50, 159, 50, 3, remote_dt);
    finish_blast(159, 50);
    repeat (2) @(negedge clk);

    // C edge in the expiry cycle is dropped; no second bomb follows.
    bomb_cycle(300, 200, 303, 194, 6, FUSE);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt += int'(bomb_active);
    end
    check("expiry edge dropped", cnt, 0);

    // C edge during BLAST is ignored.
    bomb_cycle(300, 200, 303, 194, 0, FUSE);
    c_btn = 1'b1;
    @(negedge clk);
    c_btn = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt += int'(bomb_active);
    end
    check("blast edge ignored", cnt, 0);

    // Reset part-way through the fuse clears everything and suppresses the pulse.
    place(400, 300, rise_k);
    check("rise latency rst", rise_k, 4);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset clears active", bomb_active, 0);
    check("reset clears bomb_x", bomb_x, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      cnt += int'(explosion_SCEN) + int'(bomb_active);
    end
    check("no pulse after reset", cnt, 0);

    // Randomized placements against the reference model.
    for (int r = 0; r < 20; r++) begin
      bx  = 143 + int'($urandom_range(0, 631));
      by  = 34 + int'($urandom_range(0, 400));
      ebx = snap_ref(bx, 143);
      eby = snap_ref(by, 34);
      if ($urandom_range(0, 3) == 0) begin
        game_over = 1'b1;
        place(bx, by, rise_k);
        check("rand game_over", rise_k, -1);
        game_over = 1'b0;
        repeat (2) @(negedge clk);
      end else begin
        bomb_cycle(bx, by, ebx, eby, 0, FUSE);
        for (int p = 0; p < 8; p++) begin
          vx = ebx + int'($urandom_range(0, 140)) - 70;
          vy = eby + int'($urandom_range(0, 140)) - 70;
          if (vy < 0) vy = 0;
          if (vx > 1023) vx = 1023;
          v_x = 10'(vx); v_y = 10'(vy); #0.5;
          check("rand exp_on", exp_on, exp_ref(vx, vy, ebx, eby));
        end
        finish_blast(ebx, eby);
        repeat (2) @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
